// File: rtl/operand_fetch.sv
// Operand fetch: decode request -> register-file read -> operand hand-off to execute, plus a registered writeback path.
// Latency: accept at edge N, read_en in cycle N+1, op_valid in cycle N+2 with same-cycle regComplete; writeback lands one cycle after wb_valid.
// Backpressure: dec_ready only in IDLE; operands held stable until op_ready; writeback path never stalls. Optional RF_BYPASS_EN forwards data_in into operands.
module operand_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_use_rs2,
    output logic        dec_ready,
    output logic [4:0]  selRS1,
    output logic [4:0]  selRS2,
    output logic        reg_select,
    output logic        read_en,
    input  logic [31:0] data_out1,
    input  logic [31:0] data_out2,
    input  logic        regComplete,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [4:0]  selRD,
    output logic [31:0] data_in,
    output logic        rdwrite,
    output logic        op_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        op_ready,
    output logic        rf_err
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, ERR} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic        use_rs2_q, use_rs2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        rdwrite_q, rdwrite_d;
    logic [4:0]  selrd_q, selrd_d;
    logic [31:0] data_in_q, data_in_d;

    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rd_a;
    logic [31:0] rd_b;

    assign rs1_used = (rs1_q != 5'd0);
    assign rs2_used = use_rs2_q && (rs2_q != 5'd0);

    // Operand values captured on regComplete; x0 and unused sources read as zero.
    always_comb begin
        rd_a = 32'd0;
        rd_b = 32'd0;
`ifdef RF_BYPASS_EN
        if (rs1_used) begin
            rd_a = (rdwrite_q && selrd_q == rs1_q) ? data_in_q : data_out1;
        end
        if (rs2_used) begin
            rd_b = (rdwrite_q && selrd_q == rs2_q) ? data_in_q : data_out2;
        end
`else
        if (rs1_used) begin
            rd_a = data_out1;
        end
        if (rs2_used) begin
            rd_b = data_out2;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        use_rs2_d  = use_rs2_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        dec_ready  = 1'b0;
        read_en    = 1'b0;
        reg_select = 1'b0;
        op_valid   = 1'b0;
        rf_err     = 1'b0;
        case (state_q)
            IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    rs1_d     = dec_rs1;
                    rs2_d     = dec_rs2;
                    use_rs2_d = dec_use_rs2;
                    cnt_d     = 8'd0;
                    // Nothing to read: both sources are x0 or unused.
                    if (dec_rs1 == 5'd0 && (!dec_use_rs2 || dec_rs2 == 5'd0)) begin
                        op_a_d  = 32'd0;
                        op_b_d  = 32'd0;
                        state_d = HOLD;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                read_en    = 1'b1;
                reg_select = use_rs2_q;
                if (regComplete) begin
                    op_a_d  = rd_a;
                    op_b_d  = rd_b;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                rf_err  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdwrite_d = wb_valid && (wb_rd != 5'd0);
        selrd_d   = rdwrite_d ? wb_rd : selrd_q;
        data_in_d = rdwrite_d ? wb_data : data_in_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            use_rs2_q <= 1'b0;
            cnt_q     <= 8'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            rdwrite_q <= 1'b0;
            selrd_q   <= 5'd0;
            data_in_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_rs2_q <= use_rs2_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rdwrite_q <= rdwrite_d;
            selrd_q   <= selrd_d;
            data_in_q <= data_in_d;
        end
    end

    assign selRS1  = rs1_q;
    assign selRS2  = rs2_q;
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign rdwrite = rdwrite_q;
    assign selRD   = selrd_q;
    assign data_in = data_in_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized read and writeback traffic against a transaction-level model.
module tb_operand_fetch;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs2;
    logic        dec_ready;
    logic [4:0]  selRS1;
    logic [4:0]  selRS2;
    logic        reg_select;
    logic        read_en;
    logic [31:0] data_out1;
    logic [31:0] data_out2;
    logic        regComplete;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  selRD;
    logic [31:0] data_in;
    logic        rdwrite;
    logic        op_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        rf_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs2(dec_use_rs2), .dec_ready(dec_ready),
        .selRS1(selRS1), .selRS2(selRS2), .reg_select(reg_select), .read_en(read_en),
        .data_out1(data_out1), .data_out2(data_out2), .regComplete(regComplete),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .selRD(selRD), .data_in(data_in), .rdwrite(rdwrite),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .rf_err(rf_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Present one decode request; returns at the negedge after the accepting edge.
    task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2);
        dec_valid   = 1'b1;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_use_rs2 = use2;
        @(negedge clk);
        dec_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b expected 1", dec_ready); end
        checks++; if ({read_en, rdwrite, op_valid, rf_err, reg_select} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {read_en, rdwrite, op_valid, rf_err, reg_select}); end
        checks++; if ({selRS1, selRS2, selRD} !== 15'd0) begin errors++; $display("FAIL reset_sel: got %h expected 0", {selRS1, selRS2, selRD}); end
        checks++; if ({data_in, op_a, op_b} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {data_in, op_a, op_b}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dec_ready !== 1'b1 || read_en !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got dec_ready=%b read_en=%b expected 1/0", dec_ready, read_en); end
    endtask

    task automatic test_basic_read();
        accept(5'd3, 5'd5, 1'b1);
        checks++; if (read_en !== 1'b1 || dec_ready !== 1'b0) begin errors++; $display("FAIL basic_read_en: got read_en=%b dec_ready=%b expected 1/0", read_en, dec_ready); end
        checks++; if (selRS1 !== 5'd3 || selRS2 !== 5'd5 || reg_select !== 1'b1) begin errors++; $display("FAIL basic_sel: got %0d/%0d/%b expected 3/5/1", selRS1, selRS2, reg_select); end
        regComplete = 1'b1; data_out1 = 32'h11; data_out2 = 32'h22;
        @(negedge clk);
        regComplete = 1'b0;
        checks++; if (op_valid !== 1'b1 || read_en !== 1'b0) begin errors++; $display("FAIL basic_op_valid: got op_valid=%b read_en=%b expected 1/0", op_valid, read_en); end
        checks++; if (op_a !== 32'h11 || op_b !== 32'h22) begin errors++; $display("FAIL basic_operands: got %h/%h expected 11/22", op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        checks++; if (op_valid !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got op_valid=%b dec_ready=%b expected 0/1", op_valid, dec_ready); end
    endtask

    task automatic test_zero_regs();
        data_out1 = 32'hFFFF_FFFF; data_out2 = 32'hFFFF_FFFF;
        accept(5'd0, 5'd0, 1'b1);
        checks++; if (read_en !== 1'b0 || op_valid !== 1'b1) begin errors++; $display("FAIL zero_skip_read: got read_en=%b op_valid=%b expected 0/1", read_en, op_valid); end
        checks++; if (op_a !== 32'd0 || op_b !== 32'd0) begin errors++; $display("FAIL zero_operands: got %h/%h expected 0/0", op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        accept(5'd4, 5'd9, 1'b0);
        checks++; if (read_en !== 1'b1 || reg_select !== 1'b0) begin errors++; $display("FAIL rs1_only_sel: got read_en=%b reg_select=%b expected 1/0", read_en, reg_select); end
        regComplete = 1'b1; data_out1 = 32'h44; data_out2 = 32'h99;
        @(negedge clk);
        regComplete = 1'b0;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h44 || op_b !== 32'd0) begin errors++; $display("FAIL rs1_only_operands: got v=%b %h/%h expected 1 44/0", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int rd_cycles = 0;
        int err_cycles = 0;
        int err_at = -1;
        int ready_at = -1;
        logic saw_op = 1'b0;
        regComplete = 1'b0;
        accept(5'd1, 5'd2, 1'b1);
        for (int i = 1; i <= TO + 6; i++) begin
            if (read_en === 1'b1) rd_cycles++;
            if (rf_err === 1'b1) begin err_cycles++; err_at = i; end
            if (op_valid === 1'b1) saw_op = 1'b1;
            if (dec_ready === 1'b1 && ready_at < 0) ready_at = i;
            @(negedge clk);
        end
        checks++; if (rd_cycles != TO) begin errors++; $display("FAIL timeout_read_cycles: got %0d expected %0d", rd_cycles, TO); end
        checks++; if (err_cycles != 1 || err_at != TO + 1) begin errors++; $display("FAIL timeout_rf_err: got %0d pulses at %0d expected 1 at %0d", err_cycles, err_at, TO + 1); end
        checks++; if (ready_at != TO + 2) begin errors++; $display("FAIL timeout_ready: got dec_ready at %0d expected %0d", ready_at, TO + 2); end
        checks++; if (saw_op !== 1'b0) begin errors++; $display("FAIL timeout_no_operands: got op_valid seen=%b expected 0", saw_op); end
    endtask

    task automatic test_writeback();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        @(negedge clk);
        checks++; if (rdwrite !== 1'b1 || selRD !== 5'd7 || data_in !== 32'hDEAD) begin errors++; $display("FAIL wb_first: got %b/%0d/%h expected 1/7/dead", rdwrite, selRD, data_in); end
        wb_rd = 5'd9; wb_data = 32'h1234;
        @(negedge clk);
        checks++; if (rdwrite !== 1'b1 || selRD !== 5'd9 || data_in !== 32'h1234) begin errors++; $display("FAIL wb_back_to_back: got %b/%0d/%h expected 1/9/1234", rdwrite, selRD, data_in); end
        wb_rd = 5'd0; wb_data = 32'h5555;
        @(negedge clk);
        checks++; if (rdwrite !== 1'b0 || selRD !== 5'd9 || data_in !== 32'h1234) begin errors++; $display("FAIL wb_x0_suppress: got %b/%0d/%h expected 0/9/1234", rdwrite, selRD, data_in); end
        wb_valid = 1'b0;
        @(negedge clk);
        checks++; if (rdwrite !== 1'b0) begin errors++; $display("FAIL wb_idle: got rdwrite=%b expected 0", rdwrite); end
    endtask

    task automatic test_random_writeback();
        logic        exp_wr;
        logic [4:0]  exp_rd;
        logic [31:0] exp_dat;
        wb_valid = 1'b1; wb_rd = 5'd1 + 5'($urandom_range(0, 30)); wb_data = $urandom;
        exp_wr = 1'b1; exp_rd = wb_rd; exp_dat = wb_data;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++; if (rdwrite !== exp_wr || selRD !== exp_rd || data_in !== exp_dat) begin errors++; $display("FAIL wb_random[%0d]: got %b/%0d/%h expected %b/%0d/%h", i, rdwrite, selRD, data_in, exp_wr, exp_rd, exp_dat); end
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data  = $urandom;
            exp_wr   = wb_valid && wb_rd != 5'd0;
            if (exp_wr) begin exp_rd = wb_rd; exp_dat = wb_data; end
        end
        wb_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
`ifdef RF_BYPASS_EN
        exp_a = 32'hBEEF;
`else
        exp_a = 32'h1;
`endif
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hBEEF;
        accept(5'd3, 5'd0, 1'b0);
        wb_valid = 1'b0;
        checks++; if (read_en !== 1'b1 || rdwrite !== 1'b1 || selRD !== 5'd3) begin errors++; $display("FAIL bypass_concurrent: got read_en=%b rdwrite=%b selRD=%0d expected 1/1/3", read_en, rdwrite, selRD); end
        regComplete = 1'b1; data_out1 = 32'h1; data_out2 = 32'h2;
        @(negedge clk);
        regComplete = 1'b0;
        checks++; if (op_valid !== 1'b1 || op_a !== exp_a) begin errors++; $display("FAIL bypass_op_a: got v=%b %h expected 1 %h", op_valid, op_a, exp_a); end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_reset_hold();
        accept(5'd2, 5'd0, 1'b0);
        regComplete = 1'b1; data_out1 = 32'hAB;
        @(negedge clk);
        regComplete = 1'b0;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hAB) begin errors++; $display("FAIL hold_before_reset: got v=%b %h expected 1 ab", op_valid, op_a); end
        reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
        @(negedge clk);
        reset = 1'b0; wb_valid = 1'b0;
        checks++; if (op_valid !== 1'b0 || op_a !== 32'd0 || dec_ready !== 1'b1) begin errors++; $display("FAIL reset_in_hold: got v=%b a=%h rdy=%b expected 0/0/1", op_valid, op_a, dec_ready); end
        checks++; if (rdwrite !== 1'b0 || selRD !== 5'd0) begin errors++; $display("FAIL reset_drops_wb: got %b/%0d expected 0/0", rdwrite, selRD); end
    endtask

    task automatic test_random_reads();
        for (int t = 0; t < 40; t++) begin
            logic [4:0]  rs1, rs2;
            logic        use2, zero, done;
            logic [31:0] d1, d2, exp_a, exp_b;
            int          delay, holdw;
            rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rs2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            use2  = 1'($urandom_range(0, 1));
            d1    = $urandom;
            d2    = $urandom;
            delay = $urandom_range(0, TO + 2);
            holdw = $urandom_range(0, 3);
            exp_a = (rs1 == 5'd0) ? 32'd0 : d1;
            exp_b = (!use2 || rs2 == 5'd0) ? 32'd0 : d2;
            zero  = (rs1 == 5'd0) && (!use2 || rs2 == 5'd0);
            checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rnd[%0d]_ready: got %b expected 1", t, dec_ready); end
            data_out1 = $urandom; data_out2 = $urandom;
            accept(rs1, rs2, use2);
            done = zero;
            if (zero) begin
                checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL rnd[%0d]_zero_read: got read_en=%b expected 0", t, read_en); end
            end else begin
                for (int i = 0; i < TO && !done; i++) begin
                    checks++; if (read_en !== 1'b1 || selRS1 !== rs1 || selRS2 !== rs2 || reg_select !== use2) begin errors++; $display("FAIL rnd[%0d]_read[%0d]: got %b %0d/%0d/%b expected 1 %0d/%0d/%b", t, i, read_en, selRS1, selRS2, reg_select, rs1, rs2, use2); end
                    if (i == delay) begin
                        regComplete = 1'b1; data_out1 = d1; data_out2 = d2; done = 1'b1;
                    end else begin
                        regComplete = 1'b0; data_out1 = $urandom; data_out2 = $urandom;
                    end
                    @(negedge clk);
                end
                regComplete = 1'b0;
            end
            if (done) begin
                for (int h = 0; h <= holdw; h++) begin
                    checks++; if (op_valid !== 1'b1 || op_a !== exp_a || op_b !== exp_b) begin errors++; $display("FAIL rnd[%0d]_hold[%0d]: got v=%b %h/%h expected 1 %h/%h", t, h, op_valid, op_a, op_b, exp_a, exp_b); end
                    data_out1 = $urandom; data_out2 = $urandom;
                    if (h == holdw) op_ready = 1'b1;
                    @(negedge clk);
                end
                op_ready = 1'b0;
                checks++; if (op_valid !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL rnd[%0d]_release: got v=%b rdy=%b expected 0/1", t, op_valid, dec_ready); end
            end else begin
                checks++; if (rf_err !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL rnd[%0d]_timeout: got rf_err=%b v=%b expected 1/0", t, rf_err, op_valid); end
                @(negedge clk);
                checks++; if (rf_err !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL rnd[%0d]_after_err: got rf_err=%b rdy=%b expected 0/1", t, rf_err, dec_ready); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs2 = 1'b0;
        data_out1 = '0; data_out2 = '0; regComplete = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; op_ready = 1'b0;
        test_reset();
        test_basic_read();
        test_zero_regs();
        test_timeout();
        test_writeback();
        test_random_writeback();
        test_bypass();
        test_reset_hold();
        test_random_reads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum READ cycles allowed without regComplete (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports dec_valid in 1, dec_rs1 in 5, dec_rs2 in 5, dec_use_rs2 in 1, dec_ready out 1: decode request handshake.
REQ-005 SHALL have ports selRS1 out 5, selRS2 out 5, reg_select out 1, read_en out 1: register-file read request.
REQ-006 SHALL have ports data_out1 in 32, data_out2 in 32, regComplete in 1: register-file read response.
REQ-007 SHALL have ports wb_valid in 1, wb_rd in 5, wb_data in 32: writeback request from execute.
REQ-008 SHALL have ports selRD out 5, data_in out 32, rdwrite out 1: register-file write drive.
REQ-009 SHALL have ports op_valid out 1, op_a out 32, op_b out 32, op_ready in 1: operand handshake to execute.
REQ-010 SHALL have port rf_err, output, 1: one-cycle pulse on read timeout.

Function
REQ-011 SHALL implement states IDLE, READ, HOLD, ERR; dec_ready=1 only in IDLE.
REQ-012 SHALL accept a request when dec_valid&&dec_ready at a posedge, latching rs1, rs2 and use_rs2.
REQ-013 SHALL go IDLE->HOLD directly, with op_a=op_b=0, when the accepted rs1==0 and (use_rs2==0 or rs2==0); otherwise IDLE->READ.
REQ-014 SHALL in READ drive read_en=1, selRS1/selRS2=latched values, reg_select=latched use_rs2; read_en=0 in all other states.
REQ-015 SHALL on regComplete=1 in READ latch op_a=(rs1==0?0:data_out1), op_b=(use_rs2==0 or rs2==0?0:data_out2), and go to HOLD.
REQ-016 SHALL count READ cycles; if the count reaches TIMEOUT_CYCLES without regComplete, go to ERR and drop the request.
REQ-017 SHALL in ERR assert rf_err=1 for exactly one cycle, then go to IDLE; operands are not presented.
REQ-018 SHALL assert op_valid=1 in HOLD with op_a/op_b stable; op_valid&&op_ready at a posedge returns to IDLE.
REQ-019 SHALL give minimum latency: accept at edge N, read_en high cycle N+1, op_valid high cycle N+2 when regComplete is high in cycle N+1.
REQ-020 SHALL register writeback: wb_valid=1 with wb_rd!=0 at edge N drives rdwrite=1, selRD=wb_rd, data_in=wb_data for exactly cycle N+1.
REQ-021 SHALL suppress writes to x0: wb_valid with wb_rd==0 leaves rdwrite=0.
REQ-022 SHALL handle back-to-back writebacks each cycle; rdwrite stays high with updated selRD/data_in.
REQ-023 SHALL run the writeback path independently of the read FSM; simultaneous read and write are both serviced.
REQ-024 SHALL hold selRD and data_in at their last values when rdwrite=0.

Reset
REQ-025 SHALL on reset go to IDLE, clear the timeout counter and latched fields, and drive dec_ready=1 in the following cycle.
REQ-026 SHALL on reset drive read_en, rdwrite, op_valid, rf_err, reg_select=0 and selRS1, selRS2, selRD, data_in, op_a, op_b=0.
REQ-027 SHALL abort any READ/HOLD in progress on reset mid-operation, discarding the request and any pending writeback.

Configuration
REQ-028 SHALL support macro RF_BYPASS_EN: when defined, latching on regComplete where rdwrite=1 and selRD equals a nonzero used source replaces that operand with data_in.
REQ-029 SHALL, without RF_BYPASS_EN, latch operands solely from data_out1/data_out2 per REQ-015.

Verification
REQ-030 SHALL check: accept rs1=3, rs2=5, use_rs2=1; regComplete same cycle with data_out1=0x11, data_out2=0x22 -> op_valid two cycles after accept, op_a=0x11, op_b=0x22.
REQ-031 SHALL check: rs1=0, rs2=0 -> no read_en, op_valid next cycle with op_a=op_b=0; rs1=4, use_rs2=0 -> reg_select=0, op_b=0.
REQ-032 SHALL check: regComplete held 0 with TIMEOUT_CYCLES=15 -> read_en high exactly 15 cycles, rf_err one cycle, then dec_ready=1.
REQ-033 SHALL check: wb_valid, wb_rd=7, wb_data=0xDEAD -> next cycle rdwrite=1, selRD=7, data_in=0xDEAD; wb_rd=0 -> rdwrite stays 0.
REQ-034 SHALL check, with RF_BYPASS_EN: rdwrite=1, selRD=3, data_in=0xBEEF coinciding with regComplete for rs1=3, data_out1=0x1 -> op_a=0xBEEF; without the macro -> op_a=0x1.
REQ-035 SHALL check: reset asserted during HOLD with op_ready=0 -> next cycle op_valid=0, op_a=0, dec_ready=1.
